// File: rtl/univ_shift_pkg.sv
// univ_shift_pkg
// Shared definitions for the universal shift register:
//   - 3-bit operation codes driven onto the 'mode' port
//   - sat_inc(), the saturating increment used for the shift counter
package univ_shift_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;

  // Counter increment that sticks at 'max' instead of wrapping.
  // Works on plain integers so callers of any counter width can use it.
  function automatic int unsigned sat_inc(input int unsigned cnt,
                                          input int unsigned max);
    return (cnt >= max) ? max : cnt + 1;
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// WIDTH-bit universal register: enable, synchronous clear, parallel load,
// logical shifts, rotates and arithmetic right shift. Tracks how many
// shift/rotate operations happened since the last load/clear (saturating
// at WIDTH) and a sticky flag for ones shifted out of the top by SHL.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   en        operation enable; all state holds when low
//   mode      operation select (codes in univ_shift_pkg)
//   d         parallel load data
//   sin_l     serial input entering bit 0 on SHL
//   sin_r     serial input entering bit WIDTH-1 on SHR
//   q         register contents
//   sout_l    q[WIDTH-1]
//   sout_r    q[0]
//   zero      high when q is all zeros
//   shift_cnt shift/rotate count since last LOAD/CLR, saturating at WIDTH
//   ovf       sticky: a 1 left bit WIDTH-1 during SHL
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
  localparam int                CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [MODE_W-1:0]   mode,
  input  logic [WIDTH-1:0]    d,
  input  logic                sin_l,
  input  logic                sin_r,
  output logic [WIDTH-1:0]    q,
  output logic                sout_l,
  output logic                sout_r,
  output logic                zero,
  output logic [CNT_W-1:0]    shift_cnt,
  output logic                ovf
);

  localparam int unsigned MAX_CNT = WIDTH;

  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH-1:0] asr_val;
  logic [WIDTH-1:0] q_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_next;

  // A one-bit register has no "rest of q" to shift along, so the shifted
  // values are built separately to keep every slice non-empty. Rotates and
  // ASR of a single bit leave it unchanged.
  generate
    if (WIDTH == 1) begin : g_narrow
      assign shl_val = sin_l;
      assign shr_val = sin_r;
      assign rol_val = q;
      assign ror_val = q;
      assign asr_val = q;
    end else begin : g_wide
      assign shl_val = {q[WIDTH-2:0], sin_l};
      assign shr_val = {sin_r, q[WIDTH-1:1]};
      assign rol_val = {q[WIDTH-2:0], q[WIDTH-1]};
      assign ror_val = {q[0], q[WIDTH-1:1]};
      assign asr_val = {q[WIDTH-1], q[WIDTH-1:1]};
    end
  endgenerate

  assign cnt_inc = CNT_W'(sat_inc(32'(shift_cnt), MAX_CNT));

  // Next-state selection for an enabled cycle. Defaults hold everything,
  // so HOLD and any unlisted code fall through to "no change".
  always_comb begin
    q_next   = q;
    cnt_next = shift_cnt;
    ovf_next = ovf;
    case (mode)
      MODE_LOAD: begin
        q_next   = d;
        cnt_next = '0;
        ovf_next = 1'b0;
      end
      MODE_SHL: begin
        q_next   = shl_val;
        cnt_next = cnt_inc;
        ovf_next = ovf | q[WIDTH-1];
      end
      MODE_SHR: begin
        q_next   = shr_val;
        cnt_next = cnt_inc;
      end
      MODE_ROL: begin
        q_next   = rol_val;
        cnt_next = cnt_inc;
      end
      MODE_ROR: begin
        q_next   = ror_val;
        cnt_next = cnt_inc;
      end
      MODE_ASR: begin
        q_next   = asr_val;
        cnt_next = cnt_inc;
      end
      MODE_CLR: begin
        q_next   = RESET_VAL;
        cnt_next = '0;
        ovf_next = 1'b0;
      end
      default: begin
        q_next   = q;
        cnt_next = shift_cnt;
        ovf_next = ovf;
      end
    endcase
  end

  // State register. Reset wins over enable and mode; with en low nothing
  // moves regardless of the other inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q         <= RESET_VAL;
      shift_cnt <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      q         <= q_next;
      shift_cnt <= cnt_next;
      ovf       <= ovf_next;
    end
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];
  assign zero   = (q == '0);

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised successor to the single-bit enabled flip-flop: a WIDTH-bit universal register with enable, synchronous clear, parallel load, logical/arithmetic shifts and rotates.
- Adds serial in/out at both ends, a saturating shift counter and a sticky overflow flag.
- Used as a building block for serialisers, CRC/LFSR datapaths and the tutorial shift/rotate exercises.

Parameters:
- WIDTH, 8, register width in bits; legal range is 1 or more.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset and by MODE_CLR.
- CNT_W, $clog2(WIDTH+1), width of shift_cnt. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low. Sampled on posedge clk only.
- en  input  1  operation enable. When low, all state holds.
- mode  input  3  operation select; encoding is in the package.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input entering at bit 0 on SHL.
- sin_r  input  1  serial input entering at bit WIDTH-1 on SHR.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational from q.
- sout_r  output  1  q[0], combinational from q.
- zero  output  1  high when q == 0, combinational from q.
- shift_cnt  output  CNT_W  number of shift/rotate operations since the last LOAD/CLR; saturates at WIDTH.
- ovf  output  1  sticky flag: a 1 was shifted out of bit WIDTH-1 by SHL.

Behaviour:
- Reset: on posedge clk with rst==0, set q=RESET_VAL, shift_cnt=0, ovf=0. Reset has priority over en and mode.
- en==0: q, shift_cnt and ovf all hold. mode, d and serial inputs are ignored.
- With en==1, each posedge performs exactly one operation. All results are visible the cycle after the edge (single-cycle latency).
  - MODE_HOLD (0): no change to any state.
  - MODE_LOAD (1): q<=d; shift_cnt<=0; ovf<=0.
  - MODE_SHL (2): q<={q[WIDTH-2:0],sin_l}; ovf<=ovf|q[WIDTH-1]; count++.
  - MODE_SHR (3): q<={sin_r,q[WIDTH-1:1]}; count++.
  - MODE_ROL (4): q<={q[WIDTH-2:0],q[WIDTH-1]}; count++.
  - MODE_ROR (5): q<={q[0],q[WIDTH-1:1]}; count++.
  - MODE_ASR (6): q<={q[WIDTH-1],q[WIDTH-1:1]}, i.e. the sign bit is replicated; count++.
  - MODE_CLR (7): q<=RESET_VAL; shift_cnt<=0; ovf<=0.
- count++ means shift_cnt<=min(shift_cnt+1, WIDTH). It saturates and never wraps.
- WIDTH==1 special cases:
  - SHL gives q<=sin_l; SHR gives q<=sin_r.
  - ROL, ROR and ASR leave q unchanged but still count.
  - The implementation must not produce zero-width slices in this case.
- ovf:
  - Cleared only by reset, LOAD or CLR.
  - SHR, ROL, ROR and ASR never set it.
- Reset mid-sequence discards any in-progress serial pattern; no partial state is retained.
- Outputs are never X after the first reset edge.

Decomposition:
- Package univ_shift_pkg holds:
  - mode localparams MODE_HOLD..MODE_CLR (3-bit);
  - a function sat_inc(cnt, max) used for shift_cnt.
- Single flat module; no sub-module is needed.
- The next-state mux is one combinational always block, feeding one sequential always block.

Test Plan:
- Reset/enable: WIDTH=8, hold rst=0 for 2 cycles with en=1, mode=LOAD, d=8'hFF -> q=8'h00, shift_cnt=0, ovf=0, zero=1. Release rst, LOAD 8'hA5 with en=0 -> q stays 8'h00.
- Load then SHL with overflow: LOAD 8'h81; SHL with sin_l=1 -> q=8'h03, ovf=1, shift_cnt=1. Then SHL with sin_l=0 -> q=8'h06, ovf stays 1.
- Rotate and saturation: LOAD 8'h01; 10 consecutive ROL -> q sequence 02,04,...,80,01,02,04 (final q=8'h04). shift_cnt reaches 8 and stays 8. ovf=0.
- Arithmetic vs logical right shift: LOAD 8'h90; ASR -> 8'hC8; ASR -> 8'hE4. LOAD 8'h90; SHR with sin_r=0 -> 8'h48. sout_r tracks q[0] each cycle.
- Priority/simultaneous events: with q=8'h5A and ovf=1, assert rst=0 together with en=1, mode=SHL -> q=8'h00, ovf=0, shift_cnt=0. Then CLR -> q=RESET_VAL, zero=1.
- WIDTH=1 instance: SHL with sin_l=1 -> q=1. ROR -> q=1, shift_cnt=1. SHR with sin_r=0 -> q=0, zero=1, shift_cnt saturates at 1.
